// File: rtl/tmds_lock_controller_if.sv
// Link-lock bundle between the TMDS lock controller and the receiver front end.
interface tmds_lock_controller_if #(
  parameter int WINDOW_BITS = 12
);
  logic                 pll_locked;
  logic                 ctrl_hit;
  logic [3:0]           phase;
  logic [3:0]           pll_delay;
  logic                 searching;
  logic                 locked;
  logic [WINDOW_BITS:0] best_hits;

  modport master (
    input  pll_locked, ctrl_hit,
    output phase, pll_delay, searching, locked, best_hits
  );

  modport slave (
    output pll_locked, ctrl_hit,
    input  phase, pll_delay, searching, locked, best_hits
  );
endinterface

// File: rtl/tmds_lock_controller.sv
// TMDS alignment search: sweeps bit-slip phase (and PLL delay when
// TMDS_LOCK_DELAY_SWEEP_EN is defined), applies the best setting, monitors sync.
module tmds_lock_controller #(
  parameter int SETTLE_CYCLES = 64,
  parameter int WINDOW_BITS   = 12,
  parameter int MIN_HITS      = 16,
  parameter int LOSS_BITS     = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  tmds_lock_controller_if.master bus
);

  localparam int WIN  = 2 ** WINDOW_BITS;
  localparam int TMAX = (SETTLE_CYCLES > WIN) ? SETTLE_CYCLES : WIN;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int HW   = WINDOW_BITS + 1;
  localparam int LW   = LOSS_BITS + 1;

  localparam logic [TW-1:0] SET_END = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WIN_END = TW'(WIN - 1);
  localparam logic [HW-1:0] MIN_H   = HW'(MIN_HITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_APPLY,
    S_TRACK
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic [HW-1:0] r_hit_cnt, w_hit_nxt;
  logic [HW-1:0] r_best_cnt, w_best_cnt_nxt;
  logic [3:0]    r_best_ph, w_best_ph_nxt;
  logic [3:0]    r_phase, w_phase_nxt;
  logic [HW-1:0] r_best_hits, w_best_hits_nxt;
  logic [LW-1:0] r_loss, w_loss_nxt, w_loss_inc;
  logic          r_searching, w_search_nxt;
  logic          r_locked, w_lock_nxt;
  logic          w_better, w_last;
  logic [HW-1:0] w_fin_cnt;
  logic [3:0]    w_fin_ph;
  logic [3:0]    w_delay;
  logic [3:0]    w_best_dl;

`ifdef TMDS_LOCK_DELAY_SWEEP_EN
  logic [3:0] r_delay, w_delay_nxt;
  logic [3:0] r_best_dl, w_best_dl_nxt;
  logic [3:0] w_fin_dl;

  assign w_delay   = r_delay;
  assign w_best_dl = r_best_dl;
  assign w_last    = (r_phase == 4'd9) && (r_delay == 4'd15);
  assign w_fin_dl  = w_better ? r_delay : r_best_dl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_delay   <= '0;
      r_best_dl <= '0;
    end else begin
      r_delay   <= w_delay_nxt;
      r_best_dl <= w_best_dl_nxt;
    end
  end
`else
  assign w_delay   = 4'd0;
  assign w_best_dl = 4'd0;
  assign w_last    = (r_phase == 4'd9);
`endif

  assign w_better   = r_hit_cnt > r_best_cnt;
  assign w_fin_cnt  = w_better ? r_hit_cnt : r_best_cnt;
  assign w_fin_ph   = w_better ? r_phase : r_best_ph;
  assign w_loss_inc = r_loss + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_hit_cnt   <= '0;
      r_best_cnt  <= '0;
      r_best_ph   <= '0;
      r_phase     <= '0;
      r_best_hits <= '0;
      r_loss      <= '0;
      r_searching <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_hit_cnt   <= w_hit_nxt;
      r_best_cnt  <= w_best_cnt_nxt;
      r_best_ph   <= w_best_ph_nxt;
      r_phase     <= w_phase_nxt;
      r_best_hits <= w_best_hits_nxt;
      r_loss      <= w_loss_nxt;
      r_searching <= w_search_nxt;
      r_locked    <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tmr_nxt       = r_tmr;
    w_hit_nxt       = r_hit_cnt;
    w_best_cnt_nxt  = r_best_cnt;
    w_best_ph_nxt   = r_best_ph;
    w_phase_nxt     = r_phase;
    w_best_hits_nxt = r_best_hits;
    w_loss_nxt      = '0;
`ifdef TMDS_LOCK_DELAY_SWEEP_EN
    w_delay_nxt     = r_delay;
    w_best_dl_nxt   = r_best_dl;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.pll_locked) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_tmr_nxt = r_tmr + 1'b1;
        if (r_tmr == SET_END) begin
          w_tmr_nxt   = '0;
          w_hit_nxt   = '0;
          w_state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        w_tmr_nxt = r_tmr + 1'b1;
        if (bus.ctrl_hit && (r_hit_cnt != '1))
          w_hit_nxt = r_hit_cnt + 1'b1;
        if (r_tmr == WIN_END) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        if (w_better) begin
          w_best_cnt_nxt = r_hit_cnt;
          w_best_ph_nxt  = r_phase;
`ifdef TMDS_LOCK_DELAY_SWEEP_EN
          w_best_dl_nxt  = r_delay;
`endif
        end
        if (w_last) begin
          w_best_hits_nxt = w_fin_cnt;
          if (w_fin_cnt >= MIN_H) begin
            w_phase_nxt = w_fin_ph;
`ifdef TMDS_LOCK_DELAY_SWEEP_EN
            w_delay_nxt = w_fin_dl;
`endif
            w_state_nxt = S_APPLY;
          end else begin
            // Sweep failed: forget it and start over from (0,0)
            w_best_cnt_nxt = '0;
            w_best_ph_nxt  = '0;
            w_phase_nxt    = '0;
`ifdef TMDS_LOCK_DELAY_SWEEP_EN
            w_best_dl_nxt  = '0;
            w_delay_nxt    = '0;
`endif
            w_state_nxt    = S_SETTLE;
          end
        end else begin
          w_state_nxt = S_SETTLE;
          if (r_phase == 4'd9) begin
            w_phase_nxt = '0;
`ifdef TMDS_LOCK_DELAY_SWEEP_EN
            w_delay_nxt = r_delay + 4'd1;
`endif
          end else begin
            w_phase_nxt = r_phase + 4'd1;
          end
        end
      end
      S_APPLY: begin
        w_tmr_nxt = r_tmr + 1'b1;
        if (r_tmr == SET_END) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        // A hit on the would-be loss cycle still clears the counter
        w_loss_nxt = bus.ctrl_hit ? '0 : w_loss_inc;
        if (w_loss_nxt[LW-1]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if ((r_state != S_IDLE) && !bus.pll_locked) w_state_nxt = S_IDLE;

    if (w_state_nxt == S_IDLE) begin
      w_tmr_nxt      = '0;
      w_hit_nxt      = '0;
      w_best_cnt_nxt = '0;
      w_best_ph_nxt  = '0;
      w_phase_nxt    = '0;
      w_loss_nxt     = '0;
`ifdef TMDS_LOCK_DELAY_SWEEP_EN
      w_best_dl_nxt  = '0;
      w_delay_nxt    = '0;
`endif
    end

    w_search_nxt = w_state_nxt inside {S_SETTLE, S_MEASURE, S_EVAL, S_APPLY};
    w_lock_nxt   = (w_state_nxt == S_TRACK);
  end

  assign bus.phase     = r_phase;
  assign bus.pll_delay = w_delay;
  assign bus.searching = r_searching;
  assign bus.locked    = r_locked;
  assign bus.best_hits = r_best_hits;

endmodule

// File: doc/tmds_lock_controller.md
# tmds_lock_controller

Sequences the TMDS receiver's alignment search in the pixel clock domain. It sweeps the bit-slip phase (0..9) and, optionally, the PLL fine delay (0..15), and counts channel-0 control-word hits over a fixed window at each setting. It then applies the best setting and monitors the link, restarting the search on loss of sync or loss of PLL lock. It sits between the channel-0 8b10b decoder's sync-valid output and the phase/delay inputs of the raw decoder, clock-crosser and PLL.

## Interface
Parameters:
- SETTLE_CYCLES, 64: cycles spent in SETTLE after each setting change.
- WINDOW_BITS, 12: the measure window is 2^WINDOW_BITS cycles.
- MIN_HITS, 16: minimum best hit count accepted as a valid lock.
- LOSS_BITS, 18: 2^LOSS_BITS consecutive hit-free cycles in TRACK means loss of sync.

Ports:
- clk  in  1  TMDS pixel clock; the only clock.
- reset  in  1  asynchronous, active-high.
- pll_locked  in  1  PLL lock indicator.
- ctrl_hit  in  1  high on each cycle the channel-0 word decodes as any CTRL pattern.
- phase  out  4  bit-slip phase, 0..9.
- pll_delay  out  4  PLL fine delay, 0..15.
- searching  out  1  high in SETTLE, MEASURE, EVAL and APPLY.
- locked  out  1  high only in TRACK.
- best_hits  out  WINDOW_BITS+1  hit count of the best setting from the last completed sweep.

## Operation
- States: IDLE, SETTLE, MEASURE, EVAL, APPLY, TRACK.
- IDLE:
  - Clears phase, pll_delay, the best record and the hit counter.
  - Goes to SETTLE on the first cycle pll_locked=1.
- SETTLE:
  - Waits exactly SETTLE_CYCLES cycles.
  - ctrl_hit is ignored.
  - Then goes to MEASURE.
- MEASURE:
  - Lasts exactly 2^WINDOW_BITS cycles.
  - hit_cnt (WINDOW_BITS+1 bits, cleared on entry) increments on each ctrl_hit and saturates.
- EVAL (1 cycle):
  - If hit_cnt > best_cnt (strictly greater), the best record takes {hit_cnt, phase, pll_delay}. Ties keep the earlier setting.
  - Advance: phase 9 wraps to 0 and pll_delay increments; otherwise phase increments.
  - After the last combination, compare best_cnt with MIN_HITS:
    - best_cnt ≥ MIN_HITS: load the best phase/pll_delay and go to APPLY.
    - Otherwise: clear the best record, set phase=0, pll_delay=0, and go to SETTLE (a new sweep).
  - Otherwise go to SETTLE.
  - best_hits updates when the sweep completes, in both cases.
- APPLY:
  - Waits SETTLE_CYCLES cycles.
  - Then goes to TRACK.
- TRACK:
  - locked=1.
  - A loss counter (LOSS_BITS+1 bits) clears on every ctrl_hit and otherwise increments.
  - When its MSB sets, go to IDLE.
- pll_locked=0 in any state other than IDLE forces IDLE on the next edge. This overrides all other transitions.
- Sweep order: phase fastest, then pll_delay, starting at (0,0).

## Timing
- All outputs are registered.
- Reset values: phase=0, pll_delay=0, searching=0, locked=0, best_hits=0, state IDLE.
- phase and pll_delay change only at the EVAL→SETTLE/APPLY edge or on entry to IDLE.
- Each combination takes SETTLE_CYCLES + 2^WINDOW_BITS + 1 cycles (4161 with defaults).
- locked rises on the first TRACK cycle. It falls on the cycle IDLE is entered.
- A ctrl_hit on the last MEASURE cycle is counted. A ctrl_hit on the EVAL cycle is not.
- In TRACK, a ctrl_hit in the same cycle the loss MSB would set clears the counter; no restart occurs.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous).

## Configuration
- TMDS_LOCK_DELAY_SWEEP_EN defined:
  - Sweeps 160 combinations (10 phases × 16 delays).
  - The last combination is phase=9, pll_delay=15.
- TMDS_LOCK_DELAY_SWEEP_EN undefined:
  - pll_delay is constant 0.
  - Sweeps 10 phases only; the last combination is phase=9.
  - The delay-advance logic is not built.

## Test plan
Bench parameters: SETTLE_CYCLES=4, WINDOW_BITS=4, MIN_HITS=2, LOSS_BITS=6.
- Reset: assert reset mid-MEASURE → all outputs 0 asynchronously. Hold pll_locked=0 → stays IDLE, searching=0.
- Sweep (macro on): drive ctrl_hit=1 only when phase=7 and pll_delay=3 → after 160×21 cycles from SETTLE entry, APPLY loads (7,3); locked=1 four cycles later; best_hits=16.
- Tie: 5 hits each at (2,0) and (5,4), none elsewhere → applies (2,0); best_hits=5.
- No lock: ctrl_hit=0 throughout → best_hits=0 after each sweep; sweep restarts at (0,0); locked never rises.
- Loss:
  - In TRACK, stop ctrl_hit → locked falls 64 cycles after the last hit, then the search restarts.
  - Separately, drop pll_locked → IDLE on the next edge.
- Macro off: hits only at phase=4 → pll_delay stays 0; lock at phase=4 after 10×21 cycles.
